// File: rtl/bias_bank_seq_if.sv
// ---------------------------------------------------------------------------
// bias_bank_seq_if
//   Bundles the load handshake and the read/readback bus of bias_bank_seq.
//
//   Load side : load_valid, load_ready, load_data
//   Read side : rd_req, use_ext, z (external index)
//   Result    : BIAS, bias_valid, bank_full, sel_err
//
//   master : the loader / accumulator side that drives loads and reads
//   slave  : the bias bank itself
// ---------------------------------------------------------------------------
interface bias_bank_seq_if #(
  parameter int N_adder_tree = 16,
  parameter int BIAS_W       = 18,
  parameter int SEL_W        = 4
);
  logic                           load_valid;
  logic                           load_ready;
  logic [N_adder_tree*BIAS_W-1:0] load_data;
  logic                           rd_req;
  logic                           use_ext;
  logic [SEL_W-1:0]               z;
  logic [N_adder_tree*BIAS_W-1:0] BIAS;
  logic                           bias_valid;
  logic                           bank_full;
  logic                           sel_err;

  modport master (
    output load_valid, load_data, rd_req, use_ext, z,
    input  load_ready, BIAS, bias_valid, bank_full, sel_err
  );

  modport slave (
    input  load_valid, load_data, rd_req, use_ext, z,
    output load_ready, BIAS, bias_valid, bank_full, sel_err
  );
endinterface

// File: rtl/bias_bank_seq.sv
// ---------------------------------------------------------------------------
// bias_bank_seq
//   Bank of N_BANKS bias vectors (N_adder_tree lanes of BIAS_W bits each).
//   Vectors are written one per load beat in index order; once the bank is
//   full, vectors are read back through a registered output, addressed either
//   by the external index z or by an internal auto-advancing pointer.
//
//   Ports
//     clk    : clock, all state on the rising edge
//     rst_n  : asynchronous active-low reset
//     clear  : synchronous flush (empties the bank, zeroes pointers and BIAS)
//     bus    : slave side of bias_bank_seq_if
//              load_valid/load_ready/load_data : load handshake
//              rd_req/use_ext/z                : read request and index select
//              BIAS/bias_valid                 : registered vector + strobe
//              bank_full                       : all vectors loaded
//              sel_err                         : strobe, read index out of range
// ---------------------------------------------------------------------------
module bias_bank_seq #(
  parameter int N_adder_tree = 16,
  parameter int BIAS_W       = 18,
  parameter int N_BANKS      = 16,
  parameter int SEL_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  bias_bank_seq_if.slave   bus
);

  localparam int VEC_W = N_adder_tree * BIAS_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_BANKS - 1);
  // One extra bit so the range compare works when N_BANKS == 2^SEL_W.
  localparam logic [SEL_W:0]   BANK_CNT = (SEL_W + 1)'(N_BANKS);

  logic [VEC_W-1:0] bank_q [N_BANKS];

  logic [1:0]       state_q,      state_d;
  logic [SEL_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [SEL_W-1:0] rd_ptr_q,     rd_ptr_d;
  logic [VEC_W-1:0] bias_q,       bias_d;
  logic             bias_valid_q, bias_valid_d;
  logic             sel_err_q,    sel_err_d;
  logic             bank_full_q,  bank_full_d;

  logic             load_ready;
  logic             load_beat;
  logic             bank_we;
  logic             rd_accept;
  logic [SEL_W-1:0] rd_idx;
  logic             idx_ok;
  logic [VEC_W-1:0] rd_word;

  // Ready depends on state only, never on load_valid.
  assign load_ready = (state_q != ST_READY);
  assign load_beat  = bus.load_valid & load_ready;
  assign bank_we    = load_beat & ~clear;

  assign rd_accept  = (state_q == ST_READY) & bus.rd_req;
  assign rd_idx     = bus.use_ext ? bus.z : rd_ptr_q;
  assign idx_ok     = ({1'b0, rd_idx} < BANK_CNT);

  always_comb begin
    rd_word = '0;
    if (idx_ok) begin
      rd_word = bank_q[rd_idx];
    end
  end

  // Storage is deliberately left out of reset; validity is tracked by state.
  for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
    always_ff @(posedge clk) begin
      if (bank_we && (wr_ptr_q == SEL_W'(gi))) begin
        bank_q[gi] <= bus.load_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    bias_d       = bias_q;
    bias_valid_d = 1'b0;
    sel_err_d    = 1'b0;

    if (clear) begin
      // Flush wins over any load or read in the same cycle.
      state_d  = ST_EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      bias_d   = '0;
    end else begin
      if (load_beat) begin
        if (wr_ptr_q == LAST_IDX) begin
          wr_ptr_d = '0;
          state_d  = ST_READY;
        end else begin
          wr_ptr_d = wr_ptr_q + SEL_W'(1);
          state_d  = ST_LOAD;
        end
      end

      // Loads and reads are mutually exclusive: loads only outside READY.
      if (rd_accept) begin
        bias_valid_d = 1'b1;
        if (idx_ok) begin
          bias_d = rd_word;
        end else begin
          bias_d    = '0;
          sel_err_d = 1'b1;
        end
        if (!bus.use_ext) begin
          rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + SEL_W'(1);
        end
      end
    end

    bank_full_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      bias_q       <= '0;
      bias_valid_q <= 1'b0;
      sel_err_q    <= 1'b0;
      bank_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      bias_q       <= bias_d;
      bias_valid_q <= bias_valid_d;
      sel_err_q    <= sel_err_d;
      bank_full_q  <= bank_full_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.BIAS       = bias_q;
  assign bus.bias_valid = bias_valid_q;
  assign bus.bank_full  = bank_full_q;
  assign bus.sel_err    = sel_err_q;

endmodule
